semaphore_ctrl: RTL and testbench

Traffic-light phase controller for a two-road intersection (main/side) with pedestrian request. Sequences the lights through green/yellow/all-red phases, requests each phase duration from the downstream phase timer (counter block) via a start/done handshake, and advances on timer expiry. Sits directly upstream of the phase timer: drives its start and load value, consumes its done.

---
 rtl/semaphore_pkg.sv | 51 +++++
 rtl/semaphore_ctrl.sv | 128 ++++++++++++
 tb/tb_semaphore_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/semaphore_pkg.sv
// Shared constants for the intersection phase controller: state codes,
// light encodings, default phase durations and light decode helpers.
package semaphore_pkg;

    // State codes (4-bit register, values 9..15 unused)
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CLR_A     = 4'd1;
    localparam logic [3:0] S_MAIN_G    = 4'd2;
    localparam logic [3:0] S_MAIN_Y    = 4'd3;
    localparam logic [3:0] S_CLR_B     = 4'd4;
    localparam logic [3:0] S_SIDE_G    = 4'd5;
    localparam logic [3:0] S_SIDE_Y    = 4'd6;
    localparam logic [3:0] S_FLASH_ON  = 4'd7;
    localparam logic [3:0] S_FLASH_OFF = 4'd8;

    // Light encodings, {R,Y,G}
    localparam logic [2:0] LIGHT_R   = 3'b100;
    localparam logic [2:0] LIGHT_Y   = 3'b010;
    localparam logic [2:0] LIGHT_G   = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    // Default phase durations in timer cycles
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_T_MAIN_G = 40;
    localparam int DEF_T_SIDE_G = 20;
    localparam int DEF_T_YEL    = 4;
    localparam int DEF_T_CLR    = 2;
    localparam int DEF_T_FLASH  = 5;

    // Main-road light shown while in a given state
    function automatic logic [2:0] main_light_of(input logic [3:0] s);
        case (s)
            S_MAIN_G:    return LIGHT_G;
            S_MAIN_Y:    return LIGHT_Y;
            S_FLASH_ON:  return LIGHT_Y;
            S_FLASH_OFF: return LIGHT_OFF;
            default:     return LIGHT_R;
        endcase
    endfunction

    // Side-road light shown while in a given state
    function automatic logic [2:0] side_light_of(input logic [3:0] s);
        case (s)
            S_SIDE_G:    return LIGHT_G;
            S_SIDE_Y:    return LIGHT_Y;
            S_FLASH_OFF: return LIGHT_OFF;
            default:     return LIGHT_R;
        endcase
    endfunction

endpackage

// File: rtl/semaphore_ctrl.sv
// Two-road intersection phase controller. Walks the lights through
// green/yellow/all-red phases, asks the downstream phase timer for each
// phase duration and advances when the timer reports expiry.
//
// Timer handshake: tmr_start is a one-cycle pulse in the first cycle of
// every state entry (including a MAIN_G re-arm) and tmr_load carries that
// state's duration in the same cycle, holding until the next start.
// tmr_done is a one-cycle expiry pulse; it is honoured only when it does
// not coincide with tmr_start and the controller is not in IDLE. The state
// changes on the clock edge that ends the cycle in which tmr_done was seen.
module semaphore_ctrl
    import semaphore_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int T_MAIN_G = DEF_T_MAIN_G,
    parameter int T_SIDE_G = DEF_T_SIDE_G,
    parameter int T_YEL    = DEF_T_YEL,
    parameter int T_CLR    = DEF_T_CLR,
    parameter int T_FLASH  = DEF_T_FLASH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             side_car,
    input  logic             ped_req,
    input  logic             flash_mode,
    input  logic             tmr_done,
    output logic             tmr_start,
    output logic [CNT_W-1:0] tmr_load,
    output logic [2:0]       main_light,
    output logic [2:0]       side_light,
    output logic             walk,
    output logic             ped_pending,
    output logic [3:0]       state_dbg
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       is_flash;
    logic       done_ok;
    logic       rearm;
    logic       enter;
    logic       enter_side;

    // Duration requested from the timer on entry to a state
    function automatic logic [CNT_W-1:0] dur_of(input logic [3:0] s);
        case (s)
            S_MAIN_G:               return CNT_W'(T_MAIN_G);
            S_SIDE_G:               return CNT_W'(T_SIDE_G);
            S_MAIN_Y, S_SIDE_Y:     return CNT_W'(T_YEL);
            S_FLASH_ON, S_FLASH_OFF: return CNT_W'(T_FLASH);
            default:                return CNT_W'(T_CLR);
        endcase
    endfunction

    assign state_dbg = state;
    assign is_flash  = (state == S_FLASH_ON) || (state == S_FLASH_OFF);
    assign done_ok   = tmr_done && !tmr_start && (state != S_IDLE);

    // Next-state selection: flash entry/exit overrides the running timer,
    // otherwise phases advance only on an honoured timer expiry.
    always_comb begin
        state_nxt = state;
        rearm     = 1'b0;
        if (flash_mode && !is_flash) begin
            state_nxt = S_FLASH_ON;
        end else if (!flash_mode && is_flash) begin
            state_nxt = S_CLR_A;
        end else begin
            case (state)
                S_IDLE:      state_nxt = S_CLR_A;
                S_CLR_A:     if (done_ok) state_nxt = S_MAIN_G;
                S_MAIN_G: begin
                    if (done_ok) begin
                        if (side_car || ped_pending) state_nxt = S_MAIN_Y;
                        else                         rearm     = 1'b1;
                    end
                end
                S_MAIN_Y:    if (done_ok) state_nxt = S_CLR_B;
                S_CLR_B:     if (done_ok) state_nxt = S_SIDE_G;
                S_SIDE_G:    if (done_ok) state_nxt = S_SIDE_Y;
                S_SIDE_Y:    if (done_ok) state_nxt = S_CLR_A;
                S_FLASH_ON:  if (done_ok) state_nxt = S_FLASH_OFF;
                S_FLASH_OFF: if (done_ok) state_nxt = S_FLASH_ON;
                default:     state_nxt = S_IDLE;
            endcase
        end
        enter      = (state_nxt != state) || rearm;
        enter_side = enter && (state_nxt == S_SIDE_G);
    end

    // State register and timer request outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            tmr_start <= 1'b0;
            tmr_load  <= '0;
        end else begin
            state     <= state_nxt;
            tmr_start <= enter;
            if (enter) tmr_load <= dur_of(state_nxt);
        end
    end

    // Registered light outputs decoded from the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_light <= LIGHT_R;
            side_light <= LIGHT_R;
        end else begin
            main_light <= main_light_of(state_nxt);
            side_light <= side_light_of(state_nxt);
        end
    end

    // Pedestrian latch (a new request beats the clear on SIDE_G entry)
    // and walk, fixed for the whole SIDE_G phase from the latch on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_pending <= 1'b0;
            walk        <= 1'b0;
        end else begin
            ped_pending <= ped_req || (ped_pending && !enter_side);
            if (enter_side)                  walk <= ped_pending;
            else if (state_nxt != S_SIDE_G)  walk <= 1'b0;
        end
    end

endmodule

// File: tb/tb_semaphore_ctrl.sv
// Bench for semaphore_ctrl: randomized inputs, a phase-level reference
// model that predicts every timer start record, and a monitor that pops
// and compares the expected records when the DUT pulses tmr_start.
module tb_semaphore_ctrl;

    logic       clk;
    logic       reset;
    logic       side_car;
    logic       ped_req;
    logic       flash_mode;
    logic       tmr_done;
    logic       tmr_start;
    logic [7:0] tmr_load;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       ped_pending;
    logic [3:0] state_dbg;

    semaphore_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .side_car   (side_car),
        .ped_req    (ped_req),
        .flash_mode (flash_mode),
        .tmr_done   (tmr_done),
        .tmr_start  (tmr_start),
        .tmr_load   (tmr_load),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .ped_pending(ped_pending),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    // record = {load[7:0], main[2:0], side[2:0], walk, ped_pending}
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {P_IDLE, P_CLR_A, P_MAIN_G, P_MAIN_Y, P_CLR_B,
                      P_SIDE_G, P_SIDE_Y, P_FON, P_FOFF} phase_t;

    phase_t m_phase = P_IDLE;
    bit     m_first = 1'b0;   // model just issued a timer start
    bit     m_ped   = 1'b0;
    bit     m_walk  = 1'b0;

    function automatic int dur(input phase_t p);
        case (p)
            P_MAIN_G:         return 40;
            P_SIDE_G:         return 20;
            P_MAIN_Y, P_SIDE_Y: return 4;
            P_FON, P_FOFF:    return 5;
            default:          return 2;
        endcase
    endfunction

    function automatic logic [2:0] main_of(input phase_t p);
        case (p)
            P_MAIN_G:       return 3'b001;
            P_MAIN_Y, P_FON: return 3'b010;
            P_FOFF:         return 3'b000;
            default:        return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] side_of(input phase_t p);
        case (p)
            P_SIDE_G: return 3'b001;
            P_SIDE_Y: return 3'b010;
            P_FOFF:   return 3'b000;
            default:  return 3'b100;
        endcase
    endfunction

    // Phase ring followed on timer expiry
    function automatic phase_t ring_next(input phase_t p);
        case (p)
            P_CLR_A:  return P_MAIN_G;
            P_MAIN_G: return P_MAIN_Y;
            P_MAIN_Y: return P_CLR_B;
            P_CLR_B:  return P_SIDE_G;
            P_SIDE_G: return P_SIDE_Y;
            P_SIDE_Y: return P_CLR_A;
            P_FON:    return P_FOFF;
            P_FOFF:   return P_FON;
            default:  return P_CLR_A;
        endcase
    endfunction

    // Predict what happens at the coming clock edge given the inputs now driven
    task automatic model_step();
        phase_t nxt;
        bit     fl, expired, entry, rearm, ped_n;
        fl      = (m_phase == P_FON) || (m_phase == P_FOFF);
        expired = tmr_done && !m_first && (m_phase != P_IDLE);
        nxt     = m_phase;
        rearm   = 1'b0;
        if (flash_mode && !fl)          nxt = P_FON;
        else if (!flash_mode && fl)     nxt = P_CLR_A;
        else if (m_phase == P_IDLE)     nxt = P_CLR_A;
        else if (expired) begin
            if (m_phase == P_MAIN_G && !(side_car || m_ped)) rearm = 1'b1;
            else nxt = ring_next(m_phase);
        end
        entry = (nxt != m_phase) || rearm;
        if (entry && nxt == P_SIDE_G) begin
            m_walk = m_ped;
            ped_n  = ped_req;
        end else begin
            if (nxt != P_SIDE_G) m_walk = 1'b0;
            ped_n = ped_req || m_ped;
        end
        if (entry)
            exp_q.push_back({8'(dur(nxt)), main_of(nxt), side_of(nxt), m_walk, ped_n});
        m_phase = nxt;
        m_first = entry;
        m_ped   = ped_n;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset && tmr_start) begin
            n_starts++;
            if (exp_q.size() == 0) begin
                check("unexpected_start", {tmr_load, main_light, side_light, walk, ped_pending}, 32'hdead);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("start_record", {tmr_load, main_light, side_light, walk, ped_pending}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit sc, input bit pr, input bit fm, input bit dn);
        side_car   = sc;
        ped_req    = pr;
        flash_mode = fm;
        tmr_done   = dn;
        model_step();
    endtask

    task automatic run(input int n, input int sc_pct, input int pr_pct,
                       input bit fm, input bit ped_at_sg);
        for (int i = 0; i < n; i++) begin
            bit sc, pr, dn;
            @(negedge clk);
            sc = ($urandom_range(99) < sc_pct);
            pr = ($urandom_range(99) < pr_pct);
            if (ped_at_sg && m_phase == P_SIDE_G && m_first) pr = 1'b1;
            dn = ($urandom_range(3) == 0);
            drive(sc, pr, fm, dn);
        end
    endtask

    // Run until the model is settled in the requested phase; expiry is a failure
    task automatic run_until(input phase_t p, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (m_phase == p && !m_first) break;
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, ($urandom_range(2) == 0));
        end
        check("reach_phase_in_budget", (i < budget), 1);
    endtask

    task automatic check_reset_values();
        check("rst_main_light",  main_light,  3'b100);
        check("rst_side_light",  side_light,  3'b100);
        check("rst_walk",        walk,        1'b0);
        check("rst_ped_pending", ped_pending, 1'b0);
        check("rst_tmr_start",   tmr_start,   1'b0);
        check("rst_tmr_load",    tmr_load,    8'd0);
    endtask

    // Release reset at a falling edge with a stray tmr_done, which must be ignored
    task automatic release_reset();
        @(negedge clk);
        reset   = 1'b1;
        m_phase = P_IDLE;
        m_first = 1'b0;
        m_ped   = 1'b0;
        m_walk  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        side_car   = 1'b0;
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        tmr_done   = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        release_reset();

        // quiet road: MAIN_G keeps re-arming
        run(60, 0, 0, 1'b0, 1'b0);
        // side traffic cycles through all phases
        run(200, 60, 0, 1'b0, 1'b0);
        // pedestrian requests only, including presses on SIDE_G entry
        run(300, 0, 3, 1'b0, 1'b1);
        // mixed traffic
        run(300, 30, 10, 1'b0, 1'b1);

        // flash mode entered in the middle of SIDE_G, then left again
        run_until(P_SIDE_G, 2000);
        run(40, 50, 5, 1'b1, 1'b0);
        run(80, 50, 5, 1'b0, 1'b0);

        // asynchronous reset in the middle of MAIN_Y
        run_until(P_MAIN_Y, 2000);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_reset_values();
        release_reset();
        run(150, 40, 5, 1'b0, 1'b1);

        // drain: hold inputs quiet so nothing is in flight
        run(3, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("queue_empty_at_end", exp_q.size(), 0);
        check("enough_starts_seen", (n_starts >= 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
